data_mem_hs: RTL and testbench

- Parametrised, handshaked successor to the core data memory: byte-addressable RV32 load/store memory with configurable depth and optional output register stage.
- Requests use a valid/ready channel. Responses are returned in order on a second valid/ready channel, buffered so the pipeline can back-pressure.
- Misaligned, out-of-range and illegal-funct3 accesses return an error code instead of silently proceeding.
- Sits between the LSU/MEM stage and block RAM.

---
 rtl/data_mem_hs.sv | 213 +++++++++++++++++++++
 tb/tb_data_mem_hs.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_hs.sv
// Handshaked byte-addressable RV32 data memory with in-order response queue.
// Requests and responses use independent valid/ready channels.
module data_mem_hs #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          OUT_REG     = 0,
    parameter int          RSP_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        rsp_is_load,
    output logic        busy
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          PW   = $clog2(RSP_DEPTH);
    localparam int          CW   = $clog2(RSP_DEPTH + 1);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef struct packed {
        logic        is_load;
        logic [1:0]  err;
        logic [31:0] rdata;
    } rsp_t;

    logic          accept;
    logic          f3_bad;
    logic          mis;
    logic          oor;
    logic [1:0]    err;
    logic          mem_en;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign accept = req_valid & req_ready;

    always_comb begin
        if (req_we)
            f3_bad = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            f3_bad = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        mis = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
              ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        oor = (req_addr - BASE_ADDR) >= SPAN;
        if (f3_bad)   err = 2'b11;
        else if (mis) err = 2'b01;
        else if (oor) err = 2'b10;
        else          err = 2'b00;
    end

    assign mem_en = accept & (err == 2'b00);
    // BASE_ADDR is aligned to the memory span, so low address bits index directly
    assign idx = req_addr[AW+1:2];

    always_comb begin
        be = 4'hF;
        wd = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be = 4'b0001 << req_addr[1:0];
                wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << {req_addr[1], 1'b0};
                wd = {2{req_wdata[15:0]}};
            end
            default: begin
                be = 4'hF;
                wd = req_wdata;
            end
        endcase
    end

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] s1_word;

    always_ff @(posedge clk) begin
        if (mem_en & req_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
        if (mem_en & ~req_we)
            s1_word <= mem[idx];
    end

    logic       s1_valid;
    logic [1:0] s1_off;
    logic [2:0] s1_f3;
    logic [1:0] s1_err;
    logic       s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_off   <= '0;
            s1_f3    <= '0;
            s1_err   <= '0;
            s1_load  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_off  <= req_addr[1:0];
                s1_f3   <= req_funct3;
                s1_err  <= err;
                s1_load <= ~req_we;
            end
        end
    end

    logic [31:0] sh;
    rsp_t        fmt;

    always_comb begin
        sh = s1_word >> {s1_off, 3'b000};
        fmt.is_load = s1_load;
        fmt.err     = s1_err;
        case (s1_f3)
            3'b000:  fmt.rdata = {{24{sh[7]}}, sh[7:0]};
            3'b001:  fmt.rdata = {{16{sh[15]}}, sh[15:0]};
            3'b100:  fmt.rdata = {24'b0, sh[7:0]};
            3'b101:  fmt.rdata = {16'b0, sh[15:0]};
            default: fmt.rdata = sh;
        endcase
        if (s1_err != 2'b00 || !s1_load)
            fmt.rdata = '0;
    end

    logic pipe_valid;
    rsp_t pipe_rsp;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic s2_valid;
            rsp_t s2_rsp;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_rsp   <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_rsp <= fmt;
                end
            end
            assign pipe_valid = s2_valid;
            assign pipe_rsp   = s2_rsp;
        end else begin : g_no_out_reg
            assign pipe_valid = s1_valid;
            assign pipe_rsp   = fmt;
        end
    endgenerate

    rsp_t          q [RSP_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] cnt;
    logic          live;
    logic          pop;
    rsp_t          head;

    assign pop = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (pipe_valid) q[wp] <= pipe_rsp;
    end

    // cnt covers in-flight plus queued, so the queue can never overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
            cnt  <= '0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            if (pipe_valid)
                wp <= (wp == PW'(RSP_DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop)
                rp <= (rp == PW'(RSP_DEPTH - 1)) ? '0 : rp + 1'b1;
            case ({pipe_valid, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head        = q[rp];
    assign req_ready   = live & (cnt < CW'(RSP_DEPTH));
    assign rsp_valid   = fcnt != '0;
    assign rsp_rdata   = rsp_valid ? head.rdata : '0;
    assign rsp_err     = rsp_valid ? head.err : 2'b00;
    assign rsp_is_load = rsp_valid & head.is_load;
    assign busy        = cnt != '0;

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: directed test-plan steps plus randomized traffic
// checked against a byte-level memory model and an expected-response queue.
module tb_data_mem_hs;

    localparam int DEPTH = 1024;
    localparam int RSPD  = 2;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct packed {
        logic        is_load;
        logic [1:0]  err;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        rsp_is_load;
    logic        busy;

    data_mem_hs #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR(BASE),
        .OUT_REG(0),
        .RSP_DEPTH(RSPD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_is_load(rsp_is_load),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    rsp_t        exp_q[$];
    logic [7:0]  mb [DEPTH*4];
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_err = '0;
    bit          rnd_mode = 0;

    function automatic rsp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] f3);
        rsp_t        r;
        int          sz;
        logic [31:0] off;
        logic [31:0] v;
        logic        legal;
        r.is_load = !we;
        r.rdata   = '0;
        sz  = 1 << f3[1:0];
        off = addr - BASE;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) r.err = 2'd3;
        else if ((int'(addr[1:0]) % sz) != 0) r.err = 2'd1;
        else if (off >= 32'(DEPTH * 4)) r.err = 2'd2;
        else begin
            r.err = 2'd0;
            if (we) begin
                for (int i = 0; i < sz; i++) mb[off + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[off + i];
                if (!f3[2] && sz < 4 && v[8*sz-1])
                    v = v | ~((32'h1 << (8*sz)) - 32'h1);
                r.rdata = v;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every popped response must match the oldest expected one
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                assert (0) else begin
                    fails++;
                    $error("FAIL rsp_unexpected observed=%h expected=none",
                           {rsp_is_load, rsp_err, rsp_rdata});
                end
            end else begin
                assert ({rsp_is_load, rsp_err, rsp_rdata} === exp_q[0]) else begin
                    fails++;
                    $error("FAIL rsp_order observed=%h expected=%h",
                           {rsp_is_load, rsp_err, rsp_rdata}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
        bit done = 0;
        req_we = we;
        req_addr = addr;
        req_wdata = wd;
        req_funct3 = f3;
        req_valid = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            if (rnd_mode) rsp_ready = ($urandom % 4) != 0;
            if (req_ready) begin
                exp_q.push_back(model(we, addr, wd, f3));
                done = 1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!done) chk("issue_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && (exp_q.size() != 0 || busy); c++) begin
            @(posedge clk); #1;
        end
        chk("drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic expect_last(input string tag, input logic [31:0] rd,
                               input logic [1:0] e);
        drain();
        chk({tag, "_rdata"}, last_rdata, rd);
        chk({tag, "_err"}, {30'b0, last_err}, {30'b0, e});
    endtask

    initial begin
        int          acc;
        logic [31:0] hold;
        logic [31:0] a;

        // reset state
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rel_rsp_rdata", rsp_rdata, 32'd0);
        chk("rel_rsp_err", 32'(rsp_err), 32'd0);
        chk("rel_is_load", 32'(rsp_is_load), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);

        // store then load, latency and back-to-back responses
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);
        chk("lat_not_yet", 32'(rsp_valid), 32'd0);
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("sw_rsp_rdata", rsp_rdata, 32'd0);
        chk("sw_rsp_isld", 32'(rsp_is_load), 32'd0);
        chk("sw_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        chk("lw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("lw_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("lw_rsp_isld", 32'(rsp_is_load), 32'd1);
        drain();

        // sub-word access
        issue(1'b1, 32'h13, 32'h0000_007F, 3'b000);
        issue(1'b0, 32'h13, 32'h0, 3'b000);
        expect_last("lb13", 32'h0000_007F, 2'b00);
        issue(1'b0, 32'h11, 32'h0, 3'b100);
        expect_last("lbu11", 32'h0000_00BE, 2'b00);
        issue(1'b0, 32'h12, 32'h0, 3'b001);
        expect_last("lh12", 32'h0000_7FAD, 2'b00);

        // misaligned and no side effect
        issue(1'b0, 32'h12, 32'h0, 3'b010);
        expect_last("lw12_mis", 32'h0, 2'b01);
        issue(1'b1, 32'h11, 32'h1234_5678, 3'b001);
        expect_last("sh11_mis", 32'h0, 2'b01);
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        expect_last("lw10_kept", 32'h7FAD_BEEF, 2'b00);

        // range and funct3 priority
        issue(1'b0, 32'h1000, 32'h0, 3'b010);
        expect_last("lw_oor", 32'h0, 2'b10);
        issue(1'b0, 32'h10, 32'h0, 3'b011);
        expect_last("ld_f3_011", 32'h0, 2'b11);
        issue(1'b0, 32'h1001, 32'h0, 3'b111);
        expect_last("ld_f3_111", 32'h0, 2'b11);
        issue(1'b1, 32'h3FFC, 32'h0, 3'b000);
        expect_last("sb_oor", 32'h0, 2'b10);

        // back-pressure: queue fills, output holds, then drains in order
        issue(1'b1, 32'h20, 32'h1234_5678, 3'b010);
        drain();
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_we = 1'b0;
            req_funct3 = 3'b010;
            req_addr = (i % 2 == 1) ? 32'h20 : 32'h10;
            if (req_ready) begin
                exp_q.push_back(model(1'b0, req_addr, 32'h0, 3'b010));
                acc++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'(RSPD));
        chk("bp_req_ready", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        hold = rsp_rdata;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_data", rsp_rdata, hold);
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_head_data", rsp_rdata, 32'h7FAD_BEEF);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_drained_2cyc", 32'(exp_q.size()), 32'd0);
        chk("bp_req_ready_back", 32'(req_ready), 32'd1);
        chk("bp_busy_clear", 32'(busy), 32'd0);

        // randomized traffic
        for (int w = 0; w < 16; w++)
            issue(1'b1, 32'(w * 4), $urandom, 3'b010);
        rnd_mode = 1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom % 8)
                0:       a = 32'h1000 + ($urandom % 16);
                1:       a = 32'h8000_0000 | $urandom;
                default: a = $urandom % 64;
            endcase
            issue(1'($urandom), a, $urandom, 3'($urandom));
            if ($urandom % 5 == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_mode = 0;
        drain();

        // asynchronous reset with queued responses; committed store survives
        rsp_ready = 1'b0;
        issue(1'b1, 32'h18, 32'hCAFE_F00D, 3'b010);
        issue(1'b0, 32'h10, 32'h0, 3'b010);
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 32'h18, 32'h0, 3'b010);
        expect_last("post_rst_lw", 32'hCAFE_F00D, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
